// File: rtl/control_sequencer.sv
// Hardwired Mini SRC control unit: T0-T2 fetch, then opcode-driven execute steps.
// All controls are decoded from the current T-state and the datapath's IR register.
module control_sequencer #(
  parameter int ILLEGAL_HALTS = 0
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] IR,
  input  logic        Stop,
  output logic        PC_out,
  output logic        PC_in,
  output logic        IncPC,
  output logic        MAR_in,
  output logic        Read,
  output logic        MDR_in,
  output logic        MDR_out,
  output logic        IR_in,
  output logic        Y_in,
  output logic        Z_in,
  output logic        Zlow_out,
  output logic        Zhigh_out,
  output logic        HI_in,
  output logic        LO_in,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        R_in,
  output logic        R_out,
  output logic [4:0]  alu_instruction,
  output logic        Run,
  output logic        illegal_op,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    ST_RST  = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T2   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
    ST_T6   = 4'd7,
    ST_HALT = 4'd8
  } state_t;

  state_t     r_state;
  state_t     w_next;
  state_t     w_end_state;
  logic [4:0] w_op;
  logic       w_alu3;
  logic       w_alu2;
  logic       w_muldiv;
  logic       w_nop;
  logic       w_halt;
  logic       w_unused_ir;

  assign w_op        = IR[31:27];
  assign w_unused_ir = ^IR[26:0];
  assign w_alu3      = (w_op >= 5'd3) && (w_op <= 5'd11);
  assign w_alu2      = (w_op == 5'd17) || (w_op == 5'd18);
  assign w_muldiv    = (w_op == 5'd15) || (w_op == 5'd16);
  assign w_nop       = (w_op == 5'd26);
  assign w_halt      = (w_op == 5'd27);
  assign state       = r_state;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= ST_RST;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next          = r_state;
    w_end_state     = Stop ? ST_HALT : ST_T0;
    PC_out          = 1'b0;
    PC_in           = 1'b0;
    IncPC           = 1'b0;
    MAR_in          = 1'b0;
    Read            = 1'b0;
    MDR_in          = 1'b0;
    MDR_out         = 1'b0;
    IR_in           = 1'b0;
    Y_in            = 1'b0;
    Z_in            = 1'b0;
    Zlow_out        = 1'b0;
    Zhigh_out       = 1'b0;
    HI_in           = 1'b0;
    LO_in           = 1'b0;
    Gra             = 1'b0;
    Grb             = 1'b0;
    Grc             = 1'b0;
    R_in            = 1'b0;
    R_out           = 1'b0;
    alu_instruction = 5'b00000;
    illegal_op      = 1'b0;
    Run             = (r_state != ST_RST) && (r_state != ST_HALT);

    case (r_state)
      ST_RST: w_next = ST_T0;
      ST_T0: begin
        PC_out = 1'b1;
        MAR_in = 1'b1;
        IncPC  = 1'b1;
        Z_in   = 1'b1;
        w_next = ST_T1;
      end
      ST_T1: begin
        Zlow_out = 1'b1;
        PC_in    = 1'b1;
        Read     = 1'b1;
        MDR_in   = 1'b1;
        w_next   = ST_T2;
      end
      ST_T2: begin
        MDR_out = 1'b1;
        IR_in   = 1'b1;
        w_next  = ST_T3;
      end
      ST_T3: begin
        if (w_alu3 || w_muldiv) begin
          // ALU3 latches rb into Y; MUL/DIV latches ra into Y
          Grb    = w_alu3;
          Gra    = w_muldiv;
          R_out  = 1'b1;
          Y_in   = 1'b1;
          w_next = ST_T4;
        end else if (w_alu2) begin
          Grb             = 1'b1;
          R_out           = 1'b1;
          Z_in            = 1'b1;
          alu_instruction = w_op;
          w_next          = ST_T4;
        end else if (w_nop) begin
          w_next = w_end_state;
        end else if (w_halt) begin
          w_next = ST_HALT;
        end else begin
          illegal_op = 1'b1;
          w_next     = (ILLEGAL_HALTS != 0) ? ST_HALT : w_end_state;
        end
      end
      ST_T4: begin
        if (w_alu3 || w_muldiv) begin
          Grc             = w_alu3;
          Grb             = w_muldiv;
          R_out           = 1'b1;
          Z_in            = 1'b1;
          alu_instruction = w_op;
          w_next          = ST_T5;
        end else if (w_alu2) begin
          Zlow_out = 1'b1;
          Gra      = 1'b1;
          R_in     = 1'b1;
          w_next   = w_end_state;
        end else begin
          w_next = w_end_state;
        end
      end
      ST_T5: begin
        if (w_alu3) begin
          Zlow_out = 1'b1;
          Gra      = 1'b1;
          R_in     = 1'b1;
          w_next   = w_end_state;
        end else if (w_muldiv) begin
          Zlow_out = 1'b1;
          LO_in    = 1'b1;
          w_next   = ST_T6;
        end else begin
          w_next = w_end_state;
        end
      end
      ST_T6: begin
        Zhigh_out = 1'b1;
        HI_in     = 1'b1;
        w_next    = w_end_state;
      end
      ST_HALT: w_next = ST_HALT;
      default: w_next = ST_RST;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized scoreboard bench for control_sequencer: a driver pushes expected
// per-cycle control vectors, a negedge monitor pops and compares them.
module tb_control_sequencer;

  typedef struct packed {
    logic [3:0]  st;
    logic [20:0] ctl;
    logic [4:0]  alu;
  } vec_t;

  localparam logic [20:0] M_PC_OUT  = 21'h1 << 0;
  localparam logic [20:0] M_PC_IN   = 21'h1 << 1;
  localparam logic [20:0] M_INCPC   = 21'h1 << 2;
  localparam logic [20:0] M_MAR_IN  = 21'h1 << 3;
  localparam logic [20:0] M_READ    = 21'h1 << 4;
  localparam logic [20:0] M_MDR_IN  = 21'h1 << 5;
  localparam logic [20:0] M_MDR_OUT = 21'h1 << 6;
  localparam logic [20:0] M_IR_IN   = 21'h1 << 7;
  localparam logic [20:0] M_Y_IN    = 21'h1 << 8;
  localparam logic [20:0] M_Z_IN    = 21'h1 << 9;
  localparam logic [20:0] M_ZLOW    = 21'h1 << 10;
  localparam logic [20:0] M_ZHIGH   = 21'h1 << 11;
  localparam logic [20:0] M_HI_IN   = 21'h1 << 12;
  localparam logic [20:0] M_LO_IN   = 21'h1 << 13;
  localparam logic [20:0] M_GRA     = 21'h1 << 14;
  localparam logic [20:0] M_GRB     = 21'h1 << 15;
  localparam logic [20:0] M_GRC     = 21'h1 << 16;
  localparam logic [20:0] M_R_IN    = 21'h1 << 17;
  localparam logic [20:0] M_R_OUT   = 21'h1 << 18;
  localparam logic [20:0] M_RUN     = 21'h1 << 19;
  localparam logic [20:0] M_ILL     = 21'h1 << 20;

  localparam int C_ILL = 0, C_ALU3 = 1, C_ALU2 = 2, C_MULDIV = 3, C_NOP = 4, C_HALT = 5;

  logic        clk = 1'b0;
  logic        clr, Stop, clr_h, Stop_h;
  logic [31:0] IR, IR_h;

  logic d0_PC_out, d0_PC_in, d0_IncPC, d0_MAR_in, d0_Read, d0_MDR_in, d0_MDR_out, d0_IR_in;
  logic d0_Y_in, d0_Z_in, d0_Zlow_out, d0_Zhigh_out, d0_HI_in, d0_LO_in, d0_Gra, d0_Grb, d0_Grc;
  logic d0_R_in, d0_R_out, d0_Run, d0_illegal_op;
  logic [4:0] d0_alu;
  logic [3:0] d0_state;
  logic d1_PC_out, d1_PC_in, d1_IncPC, d1_MAR_in, d1_Read, d1_MDR_in, d1_MDR_out, d1_IR_in;
  logic d1_Y_in, d1_Z_in, d1_Zlow_out, d1_Zhigh_out, d1_HI_in, d1_LO_in, d1_Gra, d1_Grb, d1_Grc;
  logic d1_R_in, d1_R_out, d1_Run, d1_illegal_op;
  logic [4:0] d1_alu;
  logic [3:0] d1_state;

  vec_t act0, act1;
  vec_t q0[$];
  vec_t q1[$];
  int   checks = 0;
  int   errors = 0;
  int   sel = 0;

  always #5 clk = ~clk;

  control_sequencer #(.ILLEGAL_HALTS(0)) dut0 (
    .clk(clk), .clr(clr), .IR(IR), .Stop(Stop),
    .PC_out(d0_PC_out), .PC_in(d0_PC_in), .IncPC(d0_IncPC), .MAR_in(d0_MAR_in),
    .Read(d0_Read), .MDR_in(d0_MDR_in), .MDR_out(d0_MDR_out), .IR_in(d0_IR_in),
    .Y_in(d0_Y_in), .Z_in(d0_Z_in), .Zlow_out(d0_Zlow_out), .Zhigh_out(d0_Zhigh_out),
    .HI_in(d0_HI_in), .LO_in(d0_LO_in), .Gra(d0_Gra), .Grb(d0_Grb), .Grc(d0_Grc),
    .R_in(d0_R_in), .R_out(d0_R_out), .alu_instruction(d0_alu), .Run(d0_Run),
    .illegal_op(d0_illegal_op), .state(d0_state)
  );

  control_sequencer #(.ILLEGAL_HALTS(1)) dut1 (
    .clk(clk), .clr(clr_h), .IR(IR_h), .Stop(Stop_h),
    .PC_out(d1_PC_out), .PC_in(d1_PC_in), .IncPC(d1_IncPC), .MAR_in(d1_MAR_in),
    .Read(d1_Read), .MDR_in(d1_MDR_in), .MDR_out(d1_MDR_out), .IR_in(d1_IR_in),
    .Y_in(d1_Y_in), .Z_in(d1_Z_in), .Zlow_out(d1_Zlow_out), .Zhigh_out(d1_Zhigh_out),
    .HI_in(d1_HI_in), .LO_in(d1_LO_in), .Gra(d1_Gra), .Grb(d1_Grb), .Grc(d1_Grc),
    .R_in(d1_R_in), .R_out(d1_R_out), .alu_instruction(d1_alu), .Run(d1_Run),
    .illegal_op(d1_illegal_op), .state(d1_state)
  );

  assign act0 = {d0_state, d0_illegal_op, d0_Run, d0_R_out, d0_R_in, d0_Grc, d0_Grb, d0_Gra,
                 d0_LO_in, d0_HI_in, d0_Zhigh_out, d0_Zlow_out, d0_Z_in, d0_Y_in, d0_IR_in,
                 d0_MDR_out, d0_MDR_in, d0_Read, d0_MAR_in, d0_IncPC, d0_PC_in, d0_PC_out, d0_alu};
  assign act1 = {d1_state, d1_illegal_op, d1_Run, d1_R_out, d1_R_in, d1_Grc, d1_Grb, d1_Gra,
                 d1_LO_in, d1_HI_in, d1_Zhigh_out, d1_Zlow_out, d1_Z_in, d1_Y_in, d1_IR_in,
                 d1_MDR_out, d1_MDR_in, d1_Read, d1_MAR_in, d1_IncPC, d1_PC_in, d1_PC_out, d1_alu};

  // ---------------- reference model ----------------
  function automatic int cls(input logic [4:0] op);
    if (op >= 5'd3 && op <= 5'd11) return C_ALU3;
    if (op == 5'd17 || op == 5'd18) return C_ALU2;
    if (op == 5'd15 || op == 5'd16) return C_MULDIV;
    if (op == 5'd26) return C_NOP;
    if (op == 5'd27) return C_HALT;
    return C_ILL;
  endfunction

  function automatic int exec_len(input int c);
    case (c)
      C_ALU3:   return 3;
      C_ALU2:   return 2;
      C_MULDIV: return 4;
      default:  return 1;
    endcase
  endfunction

  function automatic logic [20:0] exec_mask(input int c, input int k);
    logic [20:0] steps [4];
    steps = '{default: 21'h0};
    case (c)
      C_ALU3:   steps = '{M_GRB|M_R_OUT|M_Y_IN, M_GRC|M_R_OUT|M_Z_IN, M_ZLOW|M_GRA|M_R_IN, 21'h0};
      C_ALU2:   steps = '{M_GRB|M_R_OUT|M_Z_IN, M_ZLOW|M_GRA|M_R_IN, 21'h0, 21'h0};
      C_MULDIV: steps = '{M_GRA|M_R_OUT|M_Y_IN, M_GRB|M_R_OUT|M_Z_IN, M_ZLOW|M_LO_IN, M_ZHIGH|M_HI_IN};
      C_ILL:    steps = '{M_ILL, 21'h0, 21'h0, 21'h0};
      default:  steps = '{default: 21'h0};
    endcase
    return steps[k];
  endfunction

  // Run follows the state; the ALU select shows the opcode only on non-increment Z loads.
  function automatic vec_t mk(input int st, input logic [20:0] m, input logic [4:0] op);
    vec_t v;
    v.st  = st[3:0];
    v.ctl = m | ((st != 0 && st != 8) ? M_RUN : 21'h0);
    v.alu = (((v.ctl & M_Z_IN) != 0) && ((v.ctl & M_INCPC) == 0)) ? op : 5'd0;
    return v;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string name, input vec_t e, input vec_t a);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got st=%0d ctl=%h alu=%b, expected st=%0d ctl=%h alu=%b",
               name, a.st, a.ctl, a.alu, e.st, e.ctl, e.alu);
    end
  endtask

  task automatic chk_mutex(input string name, input vec_t a);
    int buses, grs;
    buses = $countones({a.ctl & (M_PC_OUT | M_MDR_OUT | M_ZLOW | M_ZHIGH | M_R_OUT)});
    grs   = $countones({a.ctl & (M_GRA | M_GRB | M_GRC)});
    checks++;
    if (buses > 1 || grs > 1) begin
      errors++;
      $display("FAIL %s mutex: got bus_drivers=%0d reg_selects=%0d, expected at most 1 each",
               name, buses, grs);
    end
  endtask

  always @(negedge clk) begin
    if (q0.size() > 0) chk("dut0_step", q0.pop_front(), act0);
    if (q1.size() > 0) chk("dut1_step", q1.pop_front(), act1);
    chk_mutex("dut0", act0);
    chk_mutex("dut1", act1);
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input vec_t e);
    if (sel == 0) q0.push_back(e);
    else          q1.push_back(e);
  endtask

  task automatic set_stop(input logic v);
    if (sel == 0) Stop = v;
    else          Stop_h = v;
  endtask

  task automatic set_ir(input logic [31:0] v);
    if (sel == 0) IR = v;
    else          IR_h = v;
  endtask

  task automatic set_clr(input logic v);
    if (sel == 0) clr = v;
    else          clr_h = v;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      set_clr(1'b1);
      set_stop(1'($urandom));
      push(mk(0, 21'h0, 5'd0));
    end
    tick();
    set_clr(1'b0);
    push(mk(0, 21'h0, 5'd0));
  endtask

  task automatic fetch();
    tick(); set_stop(1'($urandom)); push(mk(1, M_PC_OUT|M_MAR_IN|M_INCPC|M_Z_IN, 5'd0));
    tick(); set_stop(1'($urandom)); push(mk(2, M_ZLOW|M_PC_IN|M_READ|M_MDR_IN, 5'd0));
    tick(); set_stop(1'($urandom)); push(mk(3, M_MDR_OUT|M_IR_IN, 5'd0));
  endtask

  task automatic run_instr(input logic [31:0] ir, input bit stop_end, output bit halted);
    logic [4:0] op;
    int c, n;
    op = ir[31:27];
    c  = cls(op);
    n  = exec_len(c);
    fetch();
    for (int k = 0; k < n; k++) begin
      tick();
      if (k == 0) set_ir(ir);
      if (k == n - 1) set_stop((c == C_ILL) ? 1'b0 : 1'(stop_end));
      else            set_stop(1'($urandom));
      push(mk(4 + k, exec_mask(c, k), op));
    end
    halted = (c == C_HALT) || (c == C_ILL && sel == 1) ||
             (c != C_ILL && c != C_HALT && stop_end);
    $display("instr dut%0d ir=%h class=%0d stop=%0b halts=%0b", sel, ir, c, stop_end, halted);
  endtask

  task automatic hold_halt(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      set_stop(1'(i % 2));
      set_ir($urandom);
      push(mk(8, 21'h0, 5'd0));
    end
  endtask

  task automatic rand_block(input int n);
    bit h;
    for (int i = 0; i < n; i++) begin
      run_instr($urandom, ($urandom_range(0, 9) == 0), h);
      if (h) begin
        hold_halt($urandom_range(2, 5));
        do_reset($urandom_range(1, 3));
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit h;
    clr = 1'b1; Stop = 1'b0; IR = 32'h0;
    clr_h = 1'b1; Stop_h = 1'b0; IR_h = 32'h0;

    sel = 0;
    do_reset(2);
    run_instr(32'h88080000, 1'b0, h);   // neg
    run_instr(32'h18000000, 1'b0, h);   // add
    run_instr(32'h78000000, 1'b0, h);   // mul
    run_instr(32'h00000000, 1'b0, h);   // illegal, falls through to T0
    run_instr(32'hD0000000, 1'b0, h);   // nop

    // clr asserted mid-T4 of an add must clear everything without a clock edge
    fetch();
    tick(); set_ir(32'h18000000); set_stop(1'b0); push(mk(4, exec_mask(C_ALU3, 0), 5'd3));
    tick(); push(mk(5, exec_mask(C_ALU3, 1), 5'd3));
    @(negedge clk); #1;
    set_clr(1'b1);
    #1;
    chk("async_clr", mk(0, 21'h0, 5'd0), act0);
    do_reset(2);
    run_instr(32'h18000000, 1'b0, h);

    run_instr(32'hD8000000, 1'b0, h);   // halt opcode
    hold_halt(20);
    do_reset(1);
    run_instr(32'h18000000, 1'b1, h);   // Stop on last step of add
    hold_halt(3);
    do_reset(1);

    rand_block(120);

    sel = 1;
    do_reset(2);
    run_instr(32'h18000000, 1'b0, h);
    run_instr(32'h00000000, 1'b0, h);   // illegal halts in this build
    hold_halt(5);
    do_reset(1);
    rand_block(30);

    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d expectations left, expected 0/0", q0.size(), q1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
